// File: rtl/route_32_1x3_if.sv
// Valid/ready bundle between one word producer, the 1-to-3 router and its
// three consumers. The router sits on the slave side.
interface route_32_1x3_if;
  logic [31:0] in_data;
  logic [1:0]  in_select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] o0_data;
  logic [31:0] o1_data;
  logic [31:0] o2_data;
  logic        o0_valid;
  logic        o1_valid;
  logic        o2_valid;
  logic        o0_ready;
  logic        o1_ready;
  logic        o2_ready;

  modport master (
    output in_data, in_select, in_valid, o0_ready, o1_ready, o2_ready,
    input  in_ready, o0_data, o1_data, o2_data, o0_valid, o1_valid, o2_valid
  );

  modport slave (
    input  in_data, in_select, in_valid, o0_ready, o1_ready, o2_ready,
    output in_ready, o0_data, o1_data, o2_data, o0_valid, o1_valid, o2_valid
  );
endinterface

// File: rtl/route_32_1x3.sv
// Registered 1-to-3 word router with a single holding register, sticky
// bad-select flag and saturating per-port delivery counters.
module route_32_1x3 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  route_32_1x3_if.slave    bus,
  output logic             bad_sel,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q,   state_d;
  logic [31:0]      data_q,    data_d;
  logic [1:0]       dest_q,    dest_d;
  logic             bad_sel_q, bad_sel_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  logic port_ready_s;
  logic drain_s;
  logic in_ready_s;
  logic accept_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Handshake decode and next-state for the holding register and counters.
  always_comb begin
    case (dest_q)
      2'b00:   port_ready_s = bus.o0_ready;
      2'b01:   port_ready_s = bus.o1_ready;
      2'b10:   port_ready_s = bus.o2_ready;
      default: port_ready_s = 1'b0;
    endcase
    drain_s    = (state_q == ST_FULL) && port_ready_s;
    in_ready_s = (state_q == ST_EMPTY) || drain_s;
    accept_s   = bus.in_valid && in_ready_s;

    state_d   = state_q;
    data_d    = data_q;
    dest_d    = dest_q;
    bad_sel_d = bad_sel_q;

    if (accept_s) begin
      state_d = ST_FULL;
      data_d  = bus.in_data;
      if (bus.in_select == 2'b11) begin
        dest_d    = 2'b00;
        bad_sel_d = 1'b1;
      end else begin
        dest_d    = bus.in_select;
        bad_sel_d = bad_sel_q;
      end
    end else if (drain_s) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end

    for (int i = 0; i < 3; i++) begin
      if (drain_s && (dest_q == 2'(i))) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State register; reset wins over any accept or drain in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      data_q    <= 32'h0;
      dest_q    <= 2'b00;
      bad_sel_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dest_q    <= dest_d;
      bad_sel_q <= bad_sel_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.o0_valid = (state_q == ST_FULL) && (dest_q == 2'b00);
  assign bus.o1_valid = (state_q == ST_FULL) && (dest_q == 2'b01);
  assign bus.o2_valid = (state_q == ST_FULL) && (dest_q == 2'b10);
  assign bus.o0_data  = bus.o0_valid ? data_q : 32'h0;
  assign bus.o1_data  = bus.o1_valid ? data_q : 32'h0;
  assign bus.o2_data  = bus.o2_valid ? data_q : 32'h0;

  assign bad_sel = bad_sel_q;
  assign cnt0    = cnt_q[0];
  assign cnt1    = cnt_q[1];
  assign cnt2    = cnt_q[2];

endmodule

// File: tb/tb_route_32_1x3.sv
// Directed bench for route_32_1x3: main instance with 8-bit counters and a
// second instance with 2-bit counters for the saturation case.
module tb_route_32_1x3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  route_32_1x3_if bus8 ();
  route_32_1x3_if bus2 ();

  logic       bad8, bad2;
  logic [7:0] c80, c81, c82;
  logic [1:0] c20, c21, c22;

  route_32_1x3 #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave),
    .bad_sel(bad8), .cnt0(c80), .cnt1(c81), .cnt2(c82)
  );

  route_32_1x3 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave),
    .bad_sel(bad2), .cnt0(c20), .cnt1(c21), .cnt2(c22)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] v8();
    return {bus8.o2_valid, bus8.o1_valid, bus8.o0_valid};
  endfunction

  function automatic logic [31:0] port_data(input int p);
    case (p)
      0:       return bus8.o0_data;
      1:       return bus8.o1_data;
      default: return bus8.o2_data;
    endcase
  endfunction

  initial begin
    bus8.in_data = 32'h12345678; bus8.in_select = 2'b01; bus8.in_valid = 1'b1;
    bus8.o0_ready = 1'b0; bus8.o1_ready = 1'b0; bus8.o2_ready = 1'b0;
    bus2.in_data = 32'h0; bus2.in_select = 2'b00; bus2.in_valid = 1'b0;
    bus2.o0_ready = 1'b0; bus2.o1_ready = 1'b0; bus2.o2_ready = 1'b0;

    // Reset with input offered: nothing may be captured.
    rst = 1'b1;
    tick(); tick();
    check_eq("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check_eq("rst_valids", 32'(v8()), 32'd0);
    check_eq("rst_cnt", {8'h0, c80, c81, c82}, 32'd0);
    check_eq("rst_bad_sel", 32'(bad8), 32'd0);
    check_eq("rst_data", bus8.o0_data | bus8.o1_data | bus8.o2_data, 32'd0);
    rst = 1'b0; bus8.in_valid = 1'b0;
    tick();
    check_eq("idle_valids", 32'(v8()), 32'd0);

    // Basic route to port 1.
    bus8.in_data = 32'hDEADBEEF; bus8.in_select = 2'b01; bus8.in_valid = 1'b1;
    bus8.o1_ready = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    check_eq("basic_valids", 32'(v8()), 32'd2);
    check_eq("basic_o1_data", bus8.o1_data, 32'hDEADBEEF);
    check_eq("basic_o0o2_data", bus8.o0_data | bus8.o2_data, 32'd0);
    tick();
    check_eq("basic_after_valids", 32'(v8()), 32'd0);
    check_eq("basic_cnt1", 32'(c81), 32'd1);
    bus8.o1_ready = 1'b0;

    // Backpressure on port 2 while a port-0 word waits.
    bus8.in_data = 32'h11111111; bus8.in_select = 2'b10; bus8.in_valid = 1'b1;
    tick();
    bus8.in_data = 32'h22222222; bus8.in_select = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_in_ready", 32'(bus8.in_ready), 32'd0);
      check_eq("bp_valids", 32'(v8()), 32'd4);
      check_eq("bp_o2_data", bus8.o2_data, 32'h11111111);
      tick();
    end
    bus8.o0_ready = 1'b1;
    check_eq("bp_o0_ready_ignored", 32'(bus8.in_ready), 32'd0);
    bus8.o0_ready = 1'b0;
    bus8.o2_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", 32'(bus8.in_ready), 32'd1);
    tick();
    bus8.in_valid = 1'b0; bus8.o2_ready = 1'b0;
    check_eq("bp_swap_valids", 32'(v8()), 32'd1);
    check_eq("bp_o0_data", bus8.o0_data, 32'h22222222);
    check_eq("bp_cnt2", 32'(c82), 32'd1);
    bus8.o0_ready = 1'b1;
    tick();
    check_eq("bp_drain_valids", 32'(v8()), 32'd0);
    check_eq("bp_cnt0", 32'(c80), 32'd1);

    // Streaming: fresh counters, 10 words, all readies high.
    rst = 1'b1; tick(); rst = 1'b0;
    bus8.o0_ready = 1'b1; bus8.o1_ready = 1'b1; bus8.o2_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus8.in_data = 32'hA0000000 + 32'(i); bus8.in_select = 2'(i % 3); bus8.in_valid = 1'b1;
      #1;
      check_eq("stream_in_ready", 32'(bus8.in_ready), 32'd1);
      tick();
      check_eq("stream_valids", 32'(v8()), 32'(3'b001 << (i % 3)));
      check_eq("stream_data", port_data(i % 3), 32'hA0000000 + 32'(i));
    end
    bus8.in_valid = 1'b0;
    tick();
    check_eq("stream_end_valids", 32'(v8()), 32'd0);
    check_eq("stream_cnt", {8'h0, c80, c81, c82}, {8'h0, 8'd4, 8'd3, 8'd3});

    // Select 11 goes to port 0 and sets the sticky flag.
    bus8.in_data = 32'hCAFEF00D; bus8.in_select = 2'b11; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    check_eq("bad_valids", 32'(v8()), 32'd1);
    check_eq("bad_o0_data", bus8.o0_data, 32'hCAFEF00D);
    check_eq("bad_sel_set", 32'(bad8), 32'd1);
    tick();
    check_eq("bad_cnt0", 32'(c80), 32'd5);
    bus8.in_data = 32'h00000042; bus8.in_select = 2'b01; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    tick();
    check_eq("bad_sel_sticky", 32'(bad8), 32'd1);
    check_eq("bad_cnt1", 32'(c81), 32'd4);

    // Reset while a word is held on port 0 with its consumer ready.
    bus8.o0_ready = 1'b0;
    bus8.in_data = 32'h55555555; bus8.in_select = 2'b00; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    check_eq("mid_held_valids", 32'(v8()), 32'd1);
    rst = 1'b1; bus8.o0_ready = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valids", 32'(v8()), 32'd0);
    check_eq("mid_rst_cnt0", 32'(c80), 32'd0);
    check_eq("mid_rst_bad_sel", 32'(bad8), 32'd0);
    tick();
    check_eq("mid_discard_valids", 32'(v8()), 32'd0);
    check_eq("mid_discard_cnt0", 32'(c80), 32'd0);

    // Saturation on the 2-bit counter instance.
    bus2.o1_ready = 1'b1; bus2.in_select = 2'b01; bus2.in_valid = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      bus2.in_data = 32'(j);
      tick();
      check_eq("sat_cnt1_step", 32'(c21), (j - 1 > 3) ? 32'd3 : 32'(j - 1));
      check_eq("sat_o1_valid", 32'(bus2.o1_valid), 32'd1);
    end
    bus2.in_valid = 1'b0;
    tick();
    check_eq("sat_cnt1_final", 32'(c21), 32'd3);
    check_eq("sat_other_cnt", {30'h0, c20 | c22}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
